// File: rtl/date_pkg.sv
// Shared widths, encodings and helpers for the user date-setting controller.
package date_pkg;

    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 12;
    localparam int DATE_W = 21;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_DAY  = 2'd1;
    localparam logic [1:0] FIELD_MON  = 2'd2;
    localparam logic [1:0] FIELD_YEAR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_DAY  = 3'd1,
        ST_EDIT_MON  = 3'd2,
        ST_EDIT_YEAR = 3'd3,
        ST_COMMIT    = 3'd4,
        ST_PULSE     = 3'd5
    } state_e;

    typedef struct packed {
        logic [DAY_W-1:0]  day;
        logic [MON_W-1:0]  mon;
        logic [YEAR_W-1:0] year;
    } date_t;

    localparam date_t DATE_RST = '{day: 5'd1, mon: 4'd1, year: 12'd0};

    // Day is 5 bits wide, so only day 0 can be out of range on capture.
    function automatic date_t sanitize(input date_t d);
        date_t r;
        r = d;
        if (d.day == '0) r.day = 5'd1;
        if (d.mon == '0 || d.mon > 4'd12) r.mon = 4'd1;
        return r;
    endfunction

    // Step a 1..hi field by one, wrapping at both ends.
    function automatic logic [4:0] step_wrap(input logic [4:0] v, input logic [4:0] hi, input logic up);
        if (up) return (v >= hi) ? 5'd1 : v + 5'd1;
        else    return (v <= 5'd1) ? hi : v - 5'd1;
    endfunction

endpackage

// File: rtl/month_len.sv
// Days in a month for a given year. DATE_CTRL_FULL_LEAP_EN selects the full
// Gregorian leap rule; otherwise every fourth year is leap, as in date_module.
module month_len
    import date_pkg::*;
(
    input  logic [MON_W-1:0]  month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  max_day
);

    logic leap;

`ifdef DATE_CTRL_FULL_LEAP_EN
    assign leap = ((year % 12'd400) == 12'd0) ||
                  ((year[1:0] == 2'b00) && ((year % 12'd100) != 12'd0));
`else
    assign leap = (year[1:0] == 2'b00);
`endif

    always_comb begin
        max_day = 5'd31;
        case (month)
            4'd2:                     max_day = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  max_day = 5'd30;
            default:                  max_day = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_set_ctrl.sv
// User date-setting controller: capture, edit day/month/year, write back via date_ow.
// Leap rule chosen in month_len by DATE_CTRL_FULL_LEAP_EN.
module date_set_ctrl
    import date_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATE_W-1:0] date_cur,
    input  logic              btn_set,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [DATE_W-1:0] date_set,
    output logic              date_ow,
    output logic [DATE_W-1:0] date_edit,
    output logic [1:0]        field,
    output logic              editing
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    state_e            state;
    date_t             edit;
    date_t             cur;
    logic [2:0]        btn_q;
    logic              set_p, up_p, dn_p, any_p, inc, dec;
    logic [CNT_W-1:0]  cnt;
    logic              timeout;
    logic [DAY_W-1:0]  max_day, day_c;

    assign cur     = date_t'(date_cur);
    assign set_p   = btn_set  & ~btn_q[2];
    assign up_p    = btn_up   & ~btn_q[1];
    assign dn_p    = btn_down & ~btn_q[0];
    assign any_p   = set_p | up_p | dn_p;
    assign inc     = up_p & ~dn_p & ~set_p;
    assign dec     = dn_p & ~up_p & ~set_p;
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    month_len u_len (
        .month   (edit.mon),
        .year    (edit.year),
        .max_day (max_day)
    );

    assign day_c     = (edit.day > max_day) ? max_day : edit.day;
    assign date_edit = edit;

    always_comb begin
        field = FIELD_NONE;
        case (state)
            ST_EDIT_DAY:  field = FIELD_DAY;
            ST_EDIT_MON:  field = FIELD_MON;
            ST_EDIT_YEAR: field = FIELD_YEAR;
            default:      field = FIELD_NONE;
        endcase
        editing = (field != FIELD_NONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            edit     <= DATE_RST;
            date_set <= DATE_RST;
            date_ow  <= 1'b0;
            btn_q    <= '0;
            cnt      <= '0;
        end else begin
            btn_q <= {btn_set, btn_up, btn_down};
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (set_p) begin
                        edit  <= sanitize(cur);
                        state <= ST_EDIT_DAY;
                    end
                end
                ST_EDIT_DAY, ST_EDIT_MON, ST_EDIT_YEAR: begin
                    cnt <= any_p ? '0 : cnt + 1'b1;
                    if (set_p) begin
                        case (state)
                            ST_EDIT_DAY: state <= ST_EDIT_MON;
                            ST_EDIT_MON: state <= ST_EDIT_YEAR;
                            default: begin
                                // Loaded on entry to COMMIT so date_set settles a cycle before date_ow.
                                date_set <= {day_c, edit.mon, edit.year};
                                state    <= ST_COMMIT;
                            end
                        endcase
                    end else if (inc | dec) begin
                        case (state)
                            ST_EDIT_DAY: edit.day <= step_wrap(edit.day, 5'd31, inc);
                            ST_EDIT_MON: edit.mon <= MON_W'(step_wrap({1'b0, edit.mon}, 5'd12, inc));
                            default:     edit.year <= inc ? edit.year + 1'b1 : edit.year - 1'b1;
                        endcase
                    end else if (!any_p && timeout) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    cnt      <= '0;
                    date_set <= {day_c, edit.mon, edit.year};
                    date_ow  <= 1'b1;
                    state    <= ST_PULSE;
                end
                ST_PULSE: begin
                    cnt     <= '0;
                    date_ow <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    cnt     <= '0;
                    date_ow <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
